generic_rom_arb: RTL and testbench
==================================

Name: generic_rom_arb

Overview:
- Shares one single-port synchronous-read ROM (generic_rom, 1-cycle read latency) between N_PORTS requesters.
- Round-robin arbitration between requesters.
- Each accepted request is a burst of 1..2^LEN_BITS beats at incrementing addresses; the grant is held for the whole burst.
- Sits between ROM clients (boot loader, table fetchers) and a single generic_rom instance; drives the ROM address and returns read data to the owning port.

Parameters:
- N_PORTS, 2, number of requesters (1..8)
- MEM_ADDR_BITS, 10, ROM address width
- MEM_DATA_BITS, 32, ROM data width
- LEN_BITS, 4, burst length field width; beats = i_len+1

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset: synchronous, active-high
- i_req  input  N_PORTS  per-port request valid
- i_addr  input  N_PORTS*MEM_ADDR_BITS  per-port start address; port p at [p*MEM_ADDR_BITS +: MEM_ADDR_BITS]
- i_len  input  N_PORTS*LEN_BITS  per-port burst length minus one
- o_gnt  output  N_PORTS  one-hot pulse: request accepted this cycle
- o_rsp_valid  output  N_PORTS  one-hot: o_rsp_data valid for that port
- o_rsp_last  output  1  qualifies o_rsp_valid: final beat of burst
- o_rsp_data  output  MEM_DATA_BITS  read data, shared by all ports
- o_busy  output  1  burst in progress (state BURST)
- o_rom_addr  output  MEM_ADDR_BITS  ROM address
- o_rom_rd  output  1  ROM access issued this cycle
- i_rom_read_data  input  MEM_DATA_BITS  ROM read data, valid the cycle after its address

Behaviour:
- Reset (i_rst high at a rising edge): state IDLE, rr pointer = N_PORTS-1 (port 0 highest priority first). o_gnt=0, o_rsp_valid=0, o_rsp_last=0, o_busy=0, o_rom_rd=0, o_rom_addr=0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any i_req is set, pick the first requesting port after the rr pointer (cyclic). Assert o_gnt[p] combinationally, drive o_rom_addr=i_addr[p] and o_rom_rd=1, then update the rr pointer to p.
  - If i_len[p]==0, stay IDLE. Otherwise go to BURST with beat counter = 1, remaining = i_len[p], base address and owner p registered.
  - With no request: o_rom_rd=0, o_rom_addr=0.
- BURST:
  - o_rom_addr = (base + counter) mod 2^MEM_ADDR_BITS; wrap from all-ones to 0 is allowed. o_rom_rd=1, o_gnt=0.
  - Counter increments each cycle. On the cycle that issues beat i_len, return to IDLE.
  - New requests are ignored in BURST; they stay pending.
- Response pipeline:
  - One register stage of owner, last flag and valid tracks the ROM latency.
  - Beat k issued at cycle t+k gives o_rsp_valid[owner]=1 at t+k+1, with o_rsp_data = i_rom_read_data, which is passed straight through, not registered.
  - o_rsp_last=1 on beat i_len only.
  - o_rsp_data is don't-care when no o_rsp_valid is set.
- Throughput:
  - Full, one beat per cycle.
  - A new grant can occur the cycle after the last beat issues, so there is no idle bubble between bursts.
  - A burst of L+1 beats occupies L+1 address cycles.
- Requester rules:
  - Hold i_req, i_addr and i_len stable until o_gnt.
  - Drop i_req, or present a new request, the cycle after o_gnt.
  - No response backpressure; the requester must sink every beat.
- Simultaneous events:
  - Several requests in one cycle: exactly one grant, chosen round-robin.
  - A port may be granted again immediately only if no other port is requesting.
- Reset mid-burst:
  - Next cycle the FSM is IDLE and no further beats are issued.
  - o_rsp_valid is 0 in the cycle after reset, including the beat that was in flight.
  - No o_rsp_last is produced for the aborted burst.
- N_PORTS==1: degenerates to burst sequencer with grant = request in IDLE.

Test Plan:
- Port0 req addr=0x010 len=0, ROM[0x010]=0xA5A5_0010 -> o_gnt=01 at t, o_rom_addr=0x010; o_rsp_valid=01, o_rsp_last=1, data 0xA5A5_0010 at t+1.
- Ports 0 and 1 both req at t (len=0, addrs 0x020/0x030) after reset -> port0 granted t, port1 granted t+1; responses t+1 (port0) and t+2 (port1), back-to-back.
- Port1 burst addr=0x3FE len=3 -> o_rom_addr 0x3FE,0x3FF,0x000,0x001 on t..t+3; o_busy high t+1..t+3; o_rsp_valid=10 on t+1..t+4, o_rsp_last only at t+4.
- Port0 burst len=2 in progress; port1 requests at t+1 -> port1 not granted until t+3; its first response at t+4, no gap after port0's last beat.
- Both ports requesting continuously, len=0, 10 cycles -> grants alternate 01,10,01,...; exactly 5 grants each.
- Port0 burst len=7 started at t; i_rst high at t+3 -> from t+4: o_busy=0, o_rsp_valid=0, o_rom_rd=0 (unless a new request); next port0 request is granted normally.

Source files
------------

// File: rtl/generic_rom_arb.sv
// generic_rom_arb
// Shares one single-port ROM (1-cycle synchronous read) between N_PORTS
// requesters. Round-robin arbitration in IDLE; each grant starts a burst of
// i_len+1 beats at incrementing (wrapping) addresses, and the grant is held
// by staying in BURST until the last beat has been issued. Read data is
// passed straight through from the ROM, qualified by a one-stage
// valid/owner/last pipeline that tracks the ROM latency.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req             per-port request valid
//   i_addr            per-port start address, port p at [p*MEM_ADDR_BITS +: MEM_ADDR_BITS]
//   i_len             per-port burst length minus one, port p at [p*LEN_BITS +: LEN_BITS]
//   o_gnt             one-hot pulse, request of that port accepted this cycle
//   o_rsp_valid       one-hot, o_rsp_data belongs to that port this cycle
//   o_rsp_last        final beat of the burst (qualified by o_rsp_valid)
//   o_rsp_data        read data, shared by all ports
//   o_busy            burst in progress
//   o_rom_addr        ROM address
//   o_rom_rd          ROM access issued this cycle
//   i_rom_read_data   ROM read data, valid the cycle after its address
module generic_rom_arb #(
  parameter int N_PORTS       = 2,
  parameter int MEM_ADDR_BITS = 10,
  parameter int MEM_DATA_BITS = 32,
  parameter int LEN_BITS      = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [N_PORTS-1:0]                 i_req,
  input  logic [N_PORTS*MEM_ADDR_BITS-1:0]   i_addr,
  input  logic [N_PORTS*LEN_BITS-1:0]        i_len,
  output logic [N_PORTS-1:0]                 o_gnt,
  output logic [N_PORTS-1:0]                 o_rsp_valid,
  output logic                               o_rsp_last,
  output logic [MEM_DATA_BITS-1:0]           o_rsp_data,
  output logic                               o_busy,
  output logic [MEM_ADDR_BITS-1:0]           o_rom_addr,
  output logic                               o_rom_rd,
  input  logic [MEM_DATA_BITS-1:0]           i_rom_read_data
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state;
  logic [PW-1:0]            rr_ptr;    // last granted port
  logic [PW-1:0]            owner;
  logic [MEM_ADDR_BITS-1:0] base;
  logic [LEN_BITS-1:0]      cnt;       // beat index being issued in BURST
  logic [LEN_BITS-1:0]      rem;       // index of the final beat (i_len)

  logic                     rsp_vld_q;
  logic                     rsp_last_q;
  logic [PW-1:0]            rsp_owner_q;

  logic [PW-1:0]            pick;
  logic                     pick_vld;
  logic [MEM_ADDR_BITS-1:0] pick_addr;
  logic [LEN_BITS-1:0]      pick_len;

  // Round-robin search: walk from the port furthest after rr_ptr towards
  // the nearest one so the nearest requester is the last (winning) write.
  // Reset suppresses the search so no grant is shown for a request that
  // would not be accepted.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    for (int i = N_PORTS; i >= 1; i--) begin
      int idx;
      idx = (int'(rr_ptr) + i) % N_PORTS;
      if (i_req[idx] && !i_rst) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_addr = i_addr[int'(pick)*MEM_ADDR_BITS +: MEM_ADDR_BITS];
  assign pick_len  = i_len[int'(pick)*LEN_BITS +: LEN_BITS];

  always_comb begin
    o_gnt      = '0;
    o_rom_rd   = 1'b0;
    o_rom_addr = '0;
    if (state == BURST) begin
      o_rom_rd   = 1'b1;
      o_rom_addr = base + MEM_ADDR_BITS'(cnt);   // wraps modulo 2^MEM_ADDR_BITS
    end else if (pick_vld) begin
      o_gnt[pick] = 1'b1;
      o_rom_rd    = 1'b1;
      o_rom_addr  = pick_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      rr_ptr      <= PW'(N_PORTS - 1);
      owner       <= '0;
      base        <= '0;
      cnt         <= '0;
      rem         <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_owner_q <= '0;
    end else begin
      rsp_vld_q  <= 1'b0;
      rsp_last_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            rr_ptr      <= pick;
            owner       <= pick;
            base        <= pick_addr;
            rem         <= pick_len;
            cnt         <= LEN_BITS'(1);
            rsp_vld_q   <= 1'b1;
            rsp_owner_q <= pick;
            rsp_last_q  <= (pick_len == '0);
            if (pick_len != '0) state <= BURST;
          end
        end
        BURST: begin
          rsp_vld_q   <= 1'b1;
          rsp_owner_q <= owner;
          rsp_last_q  <= (cnt == rem);
          cnt         <= cnt + 1'b1;
          if (cnt == rem) state <= IDLE;   // final beat issued this cycle
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (state == BURST);
  assign o_rsp_valid = rsp_vld_q ? (N_PORTS'(1) << rsp_owner_q) : '0;
  assign o_rsp_last  = rsp_vld_q & rsp_last_q;
  assign o_rsp_data  = i_rom_read_data;

endmodule

// File: tb/tb_generic_rom_arb.sv
// tb_generic_rom_arb
// Self-checking bench for generic_rom_arb. A transaction-level model (a queue
// of pending beats plus a last-granted port) predicts every output on every
// cycle outside reset; directed scenarios then pin specific cycles of the
// logged DUT outputs against hand-computed literals.
module tb_generic_rom_arb;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 4;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_req;
  logic [N*AW-1:0] i_addr;
  logic [N*LW-1:0] i_len;
  logic [N-1:0]    o_gnt;
  logic [N-1:0]    o_rsp_valid;
  logic            o_rsp_last;
  logic [DW-1:0]   o_rsp_data;
  logic            o_busy;
  logic [AW-1:0]   o_rom_addr;
  logic            o_rom_rd;
  logic [DW-1:0]   i_rom_read_data;

  generic_rom_arb #(
    .N_PORTS(N), .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .LEN_BITS(LW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
    .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_last(o_rsp_last),
    .o_rsp_data(o_rsp_data), .o_busy(o_busy), .o_rom_addr(o_rom_addr),
    .o_rom_rd(o_rom_rd), .i_rom_read_data(i_rom_read_data)
  );

  always #5 i_clk = ~i_clk;

  // ROM contents: 0xA5A5_0000 | address.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | DW'(a);
  endfunction

  always @(posedge i_clk) if (o_rom_rd) i_rom_read_data <= rom_word(o_rom_addr);

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requester agents ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } req_t;

  req_t         pend [N][$];
  logic [N-1:0] gnt_seen;

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (pend[p].size() > 0) begin
        i_req[p]            = 1'b1;
        i_addr[p*AW +: AW]  = pend[p][0].addr;
        i_len[p*LW +: LW]   = pend[p][0].len;
      end else begin
        i_req[p]            = 1'b0;
        i_addr[p*AW +: AW]  = '0;
        i_len[p*LW +: LW]   = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    for (int p = 0; p < N; p++)
      if (gnt_seen[p] && pend[p].size() > 0) void'(pend[p].pop_front());
    gnt_seen = '0;
    drive();
  endtask

  task automatic push(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_t r;
    r.addr = a;
    r.len  = l;
    pend[p].push_back(r);
    drive();
  endtask

  // ---------------- model and per-cycle compare ----------------
  typedef struct {
    logic [AW-1:0] addr;
    int            port;
    bit            last;
  } beat_t;

  beat_t issue_q [$];
  beat_t cur, prev;
  bit    cur_vld, prev_vld = 1'b0;
  int    rr_last = N - 1;
  int    cyc = 0;

  logic [N-1:0]  d_gnt  [0:1023];
  logic [N-1:0]  d_rspv [0:1023];
  logic          d_last [0:1023];
  logic [DW-1:0] d_data [0:1023];
  logic          d_busy [0:1023];
  logic [AW-1:0] d_addr [0:1023];
  logic          d_rd   [0:1023];

  logic [N-1:0]  e_gnt, e_rspv;
  logic [AW-1:0] e_addr, m_a;
  logic [LW-1:0] m_l;
  logic [DW-1:0] e_data;
  logic          e_rd, e_busy, e_last;
  int            m_p;
  bit            m_found;

  always @(negedge i_clk) begin
    d_gnt[cyc]  = o_gnt;
    d_rspv[cyc] = o_rsp_valid;
    d_last[cyc] = o_rsp_last;
    d_data[cyc] = o_rsp_data;
    d_busy[cyc] = o_busy;
    d_addr[cyc] = o_rom_addr;
    d_rd[cyc]   = o_rom_rd;
    if (i_rst) begin
      issue_q.delete();
      rr_last  = N - 1;
      prev_vld = 1'b0;
    end else begin
      e_busy  = (issue_q.size() != 0);
      e_rspv  = prev_vld ? (N'(1) << prev.port) : '0;
      e_last  = prev_vld && prev.last;
      e_data  = rom_word(prev.addr);
      e_gnt   = '0;
      e_rd    = 1'b0;
      e_addr  = '0;
      cur_vld = 1'b0;
      if (issue_q.size() != 0) begin
        cur     = issue_q.pop_front();
        cur_vld = 1'b1;
        e_rd    = 1'b1;
        e_addr  = cur.addr;
      end else begin
        m_found = 1'b0;
        m_p     = 0;
        for (int k = 1; k <= N && !m_found; k++) begin
          m_p = (rr_last + k) % N;
          if (i_req[m_p]) m_found = 1'b1;
        end
        if (m_found) begin
          m_a          = i_addr[m_p*AW +: AW];
          m_l          = i_len[m_p*LW +: LW];
          e_gnt[m_p]   = 1'b1;
          e_rd         = 1'b1;
          e_addr       = m_a;
          rr_last      = m_p;
          cur.addr     = m_a;
          cur.port     = m_p;
          cur.last     = (m_l == 0);
          cur_vld      = 1'b1;
          for (int k = 1; k <= int'(m_l); k++) begin
            beat_t b;
            b.addr = AW'(int'(m_a) + k);
            b.port = m_p;
            b.last = (k == int'(m_l));
            issue_q.push_back(b);
          end
        end
      end
      check("gnt",       o_gnt,       e_gnt);
      check("rom_rd",    o_rom_rd,    e_rd);
      check("rom_addr",  o_rom_addr,  e_addr);
      check("busy",      o_busy,      e_busy);
      check("rsp_valid", o_rsp_valid, e_rspv);
      check("rsp_last",  o_rsp_last,  e_last);
      if (e_rspv != '0) check("rsp_data", o_rsp_data, e_data);
      prev     = cur;
      prev_vld = cur_vld;
      gnt_seen = gnt_seen | o_gnt;
    end
    cyc++;
  end

  // ---------------- helpers ----------------
  task automatic wait_idle();
    bit busy_left;
    busy_left = 1'b1;
    for (int i = 0; i < 200 && busy_left; i++) begin
      step();
      busy_left = 1'b0;
      for (int p = 0; p < N; p++) if (pend[p].size() != 0) busy_left = 1'b1;
      if (issue_q.size() != 0 || prev_vld) busy_left = 1'b1;
    end
    check("drain_timeout", busy_left, 1'b0);
    step();
    step();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  function automatic int find_gnt(input int from, input int p);
    for (int c = from; c < cyc; c++) if (d_gnt[c][p]) return c;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t, t2, c0, c1;
    i_rst    = 1'b1;
    i_req    = '0;
    i_addr   = '0;
    i_len    = '0;
    gnt_seen = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Reset state, first idle cycle.
    t = cyc;
    step();
    check("rst_gnt",      d_gnt[t],  2'b00);
    check("rst_rsp_valid", d_rspv[t], 2'b00);
    check("rst_rsp_last", d_last[t], 1'b0);
    check("rst_busy",     d_busy[t], 1'b0);
    check("rst_rom_rd",   d_rd[t],   1'b0);
    check("rst_rom_addr", d_addr[t], 10'h000);

    // Single beat from port 0.
    t = cyc;
    push(0, 10'h010, 4'd0);
    wait_idle();
    check("t1_gnt_cycle", find_gnt(t, 0), t);
    check("t1_gnt",       d_gnt[t],    2'b01);
    check("t1_addr",      d_addr[t],   10'h010);
    check("t1_rd",        d_rd[t],     1'b1);
    check("t1_rsp_valid", d_rspv[t+1], 2'b01);
    check("t1_rsp_last",  d_last[t+1], 1'b1);
    check("t1_rsp_data",  d_data[t+1], 32'hA5A5_0010);

    // Simultaneous requests right after reset: port 0 first.
    do_reset();
    t = cyc;
    push(0, 10'h020, 4'd0);
    push(1, 10'h030, 4'd0);
    wait_idle();
    check("t2_gnt0",   d_gnt[t],    2'b01);
    check("t2_gnt1",   d_gnt[t+1],  2'b10);
    check("t2_addr1",  d_addr[t+1], 10'h030);
    check("t2_rsp0",   d_rspv[t+1], 2'b01);
    check("t2_rsp1",   d_rspv[t+2], 2'b10);
    check("t2_data1",  d_data[t+2], 32'hA5A5_0030);

    // Port 1 burst wrapping the address space.
    t = cyc;
    push(1, 10'h3FE, 4'd3);
    wait_idle();
    check("t3_addr0", d_addr[t],   10'h3FE);
    check("t3_addr1", d_addr[t+1], 10'h3FF);
    check("t3_addr2", d_addr[t+2], 10'h000);
    check("t3_addr3", d_addr[t+3], 10'h001);
    check("t3_busy_t0", d_busy[t],   1'b0);
    for (int k = 1; k <= 3; k++) check("t3_busy", d_busy[t+k], 1'b1);
    check("t3_busy_end", d_busy[t+4], 1'b0);
    for (int k = 1; k <= 4; k++) check("t3_rsp_valid", d_rspv[t+k], 2'b10);
    check("t3_last_mid", d_last[t+3], 1'b0);
    check("t3_last_end", d_last[t+4], 1'b1);
    check("t3_data_wrap", d_data[t+3], 32'hA5A5_0000);

    // Port 1 arrives during port 0's burst and waits for it.
    t = cyc;
    push(0, 10'h100, 4'd2);
    step();
    push(1, 10'h200, 4'd0);
    wait_idle();
    check("t4_gnt0",   d_gnt[t],    2'b01);
    check("t4_hold1",  d_gnt[t+1],  2'b00);
    check("t4_hold2",  d_gnt[t+2],  2'b00);
    check("t4_gnt1",   d_gnt[t+3],  2'b10);
    check("t4_addr1",  d_addr[t+3], 10'h200);
    check("t4_last0",  d_rspv[t+3], 2'b01);
    check("t4_last0f", d_last[t+3], 1'b1);
    check("t4_rsp1",   d_rspv[t+4], 2'b10);

    // Both ports requesting continuously: grants alternate.
    t = cyc;
    for (int k = 0; k < 5; k++) begin
      push(0, AW'(10'h040 + k), 4'd0);
      push(1, AW'(10'h050 + k), 4'd0);
    end
    wait_idle();
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 10; k++) begin
      check("t5_alternate", d_gnt[t+k], (k % 2 == 0) ? 2'b01 : 2'b10);
      if (d_gnt[t+k][0]) c0++;
      if (d_gnt[t+k][1]) c1++;
    end
    check("t5_count0", c0, 5);
    check("t5_count1", c1, 5);
    check("t5_after",  d_gnt[t+10], 2'b00);

    // Reset in the middle of a long burst.
    t = cyc;
    push(0, 10'h080, 4'd7);
    step();
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    step();
    check("t6_addr2",     d_addr[t+2], 10'h082);
    check("t6_busy_pre",  d_busy[t+3], 1'b1);
    check("t6_busy",      d_busy[t+4], 1'b0);
    check("t6_rsp_valid", d_rspv[t+4], 2'b00);
    check("t6_rsp_last",  d_last[t+4], 1'b0);
    check("t6_rom_rd",    d_rd[t+4],   1'b0);
    t2 = cyc;
    push(0, 10'h090, 4'd0);
    wait_idle();
    check("t6_regnt",      d_gnt[t2],    2'b01);
    check("t6_regnt_rsp",  d_rspv[t2+1], 2'b01);
    check("t6_regnt_data", d_data[t2+1], 32'hA5A5_0090);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
